// File: rtl/key_encode83_pkg.sv
// Shared types, constants and encoding helpers for the keypad encoder.
// The encoder is the inverse of the team's 3-to-8 active-low decoder.
package key_encode83_pkg;

    typedef enum logic {IDLE, HELD} state_t;

    localparam logic [7:0] ALL_RELEASED = 8'hFF;

    // key[7-n] low maps to code n; lowest code wins when several keys are down
    function automatic logic [2:0] enc83(input logic [7:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int n = 7; n >= 0; n--) begin
            if (!v[7-n]) c = 3'(n);
        end
        return c;
    endfunction

    function automatic logic [3:0] popz(input logic [7:0] v);
        logic [3:0] z;
        z = 4'd0;
        for (int i = 0; i < 8; i++) begin
            z = z + {3'd0, ~v[i]};
        end
        return z;
    endfunction

endpackage

// File: rtl/key_encode83_debounce_vec.sv
// Two-flop synchroniser followed by a whole-vector debouncer: a pattern is
// accepted only after it has been seen unchanged for DB_CYCLES+1 samples.
module debounce_vec #(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 1_000_000,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] key,
    output logic [WIDTH-1:0] deb
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] cnt;

    // deb is only written while sync still agrees with cand, so a bounce on
    // the very edge the counter tops out cannot slip through
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
            cand  <= '1;
            deb   <= '1;
            cnt   <= '0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else begin
                if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
                if (cnt == CNT_MAX) deb <= cand;
            end
        end
    end

endmodule

// File: rtl/key_encode83.sv
// Keypad front end: debounces eight active-low keys, priority-encodes the
// pattern and strobes valid once per press (a release must be seen first).
module key_encode83 #(
    parameter int DB_CYCLES = 1_000_000,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key,
    output logic [2:0] code,
    output logic       valid,
    output logic       pressed,
    output logic       multi
);

    import key_encode83_pkg::*;

    logic [7:0] deb;
    state_t     state;
    state_t     state_nx;
    logic       valid_nx;
    logic [2:0] code_nx;

    debounce_vec #(
        .WIDTH    (8),
        .DB_CYCLES(DB_CYCLES),
        .CNT_W    (CNT_W)
    ) u_deb (
        .clk(clk),
        .rst(rst),
        .key(key),
        .deb(deb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            code  <= 3'b000;
            valid <= 1'b0;
            multi <= 1'b0;
        end else begin
            state <= state_nx;
            code  <= code_nx;
            valid <= valid_nx;
            multi <= (popz(deb) >= 4'd2);
        end
    end

    // Pattern changes while HELD (rollover, extra keys) are deliberately ignored
    always_comb begin
        state_nx = state;
        valid_nx = 1'b0;
        code_nx  = code;
        case (state)
            IDLE: begin
                if (deb != ALL_RELEASED) begin
                    state_nx = HELD;
                    valid_nx = 1'b1;
                    code_nx  = enc83(deb);
                end
            end
            HELD: begin
                if (deb == ALL_RELEASED) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign pressed = (state == HELD);

endmodule

// File: tb/tb_key_encode83.sv
// Directed self-checking bench for key_encode83 with DB_CYCLES = 4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_key_encode83;

    logic       clk;
    logic       rst;
    logic [7:0] key;
    logic [2:0] code;
    logic       valid;
    logic       pressed;
    logic       multi;

    int n_checks;
    int n_fail;

    key_encode83 #(.DB_CYCLES(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .key    (key),
        .code   (code),
        .valid  (valid),
        .pressed(pressed),
        .multi  (multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles and records when valid first rises (k counted from 1),
    // how often it fired, code/multi at that point, the first cycle pressed
    // and multi are low, and the number of cycles pressed was high.
    task automatic observe(input int n, output int fv, output int nv,
                           output logic [2:0] cv, output logic mv,
                           output int fpl, output int fml, output int nph);
        fv = 0; nv = 0; cv = 3'd0; mv = 1'b0; fpl = 0; fml = 0; nph = 0;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (valid === 1'b1) begin
                nv++;
                if (fv == 0) begin
                    fv = k;
                    cv = code;
                    mv = multi;
                end
            end
            if (pressed === 1'b1) nph++;
            if (pressed !== 1'b1 && fpl == 0) fpl = k;
            if (multi !== 1'b1 && fml == 0) fml = k;
        end
    endtask

    task automatic test_reset();
        int fv, nv, fpl, fml, nph;
        logic [2:0] cv;
        logic mv;
        key = 8'h00;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({code, valid, pressed, multi} !== 6'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_outputs: got code=%0d valid=%b pressed=%b multi=%b, expected all 0",
                         code, valid, pressed, multi);
            end
        end
        rst = 1'b0;
        observe(12, fv, nv, cv, mv, fpl, fml, nph);
        n_checks++;
        if (fv !== 8 || nv !== 1) begin
            n_fail++;
            $display("[TB] FAIL reset_valid_timing: got first=%0d count=%0d, expected first=8 count=1", fv, nv);
        end
        n_checks++;
        if (cv !== 3'd0 || mv !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_code_multi: got code=%0d multi=%b, expected code=0 multi=1", cv, mv);
        end
        key = 8'hFF;
        observe(12, fv, nv, cv, mv, fpl, fml, nph);
        n_checks++;
        if (fpl !== 8 || fml !== 8 || nv !== 0) begin
            n_fail++;
            $display("[TB] FAIL reset_release: got pressed_low=%0d multi_low=%0d valids=%0d, expected 8 8 0",
                     fpl, fml, nv);
        end
    endtask

    task automatic test_single_keys();
        int fv, nv, fpl, fml, nph;
        logic [2:0] cv;
        logic mv;
        logic [7:0] kv;
        logic [7:0] top;
        top = 8'h80;
        for (int n = 0; n < 8; n++) begin
            kv  = ~(top >> n);
            key = kv;
            observe(10, fv, nv, cv, mv, fpl, fml, nph);
            n_checks++;
            if (fv !== 8 || nv !== 1 || cv !== 3'(n) || mv !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL single_key_%0d: got first=%0d count=%0d code=%0d multi=%b, expected 8 1 %0d 0",
                         n, fv, nv, cv, mv, n);
            end
            n_checks++;
            if (pressed !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL single_held_%0d: got pressed=%b, expected 1", n, pressed);
            end
            key = 8'hFF;
            observe(10, fv, nv, cv, mv, fpl, fml, nph);
            n_checks++;
            if (fpl !== 8 || nv !== 0 || code !== 3'(n)) begin
                n_fail++;
                $display("[TB] FAIL single_release_%0d: got pressed_low=%0d valids=%0d code=%0d, expected 8 0 %0d",
                         n, fpl, nv, code, n);
            end
        end
    endtask

    task automatic test_bounce();
        int fv, nv, fpl, fml, nph;
        int bounce_valids;
        int bounce_pressed;
        logic [2:0] cv;
        logic mv;
        bounce_valids  = 0;
        bounce_pressed = 0;
        for (int c = 0; c < 12; c++) begin
            key = (c % 3 == 2) ? 8'hFF : 8'hEF;
            tick();
            if (valid === 1'b1) bounce_valids++;
            if (pressed === 1'b1) bounce_pressed++;
        end
        n_checks++;
        if (bounce_valids !== 0 || bounce_pressed !== 0) begin
            n_fail++;
            $display("[TB] FAIL bounce_quiet: got valids=%0d pressed_cycles=%0d, expected 0 0",
                     bounce_valids, bounce_pressed);
        end
        key = 8'hEF;
        observe(12, fv, nv, cv, mv, fpl, fml, nph);
        n_checks++;
        if (fv !== 8 || nv !== 1 || cv !== 3'd3) begin
            n_fail++;
            $display("[TB] FAIL bounce_accept: got first=%0d count=%0d code=%0d, expected 8 1 3", fv, nv, cv);
        end
        key = 8'hFF;
        observe(12, fv, nv, cv, mv, fpl, fml, nph);
        n_checks++;
        if (fpl !== 8) begin
            n_fail++;
            $display("[TB] FAIL bounce_release: got pressed_low=%0d, expected 8", fpl);
        end
    endtask

    task automatic test_multi();
        int fv, nv, fpl, fml, nph;
        logic [2:0] cv;
        logic mv;
        key = 8'b0111_1110;
        observe(10, fv, nv, cv, mv, fpl, fml, nph);
        n_checks++;
        if (fv !== 8 || nv !== 1 || cv !== 3'd0 || mv !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL multi_press: got first=%0d count=%0d code=%0d multi=%b, expected 8 1 0 1",
                     fv, nv, cv, mv);
        end
        key = 8'b1111_1110;
        observe(12, fv, nv, cv, mv, fpl, fml, nph);
        n_checks++;
        if (nv !== 0 || fml !== 8) begin
            n_fail++;
            $display("[TB] FAIL multi_rollover: got valids=%0d multi_low=%0d, expected 0 8", nv, fml);
        end
        n_checks++;
        if (code !== 3'd0 || pressed !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL multi_code_hold: got code=%0d pressed=%b, expected 0 1", code, pressed);
        end
        key = 8'hFF;
        observe(12, fv, nv, cv, mv, fpl, fml, nph);
        n_checks++;
        if (fpl !== 8 || nv !== 0) begin
            n_fail++;
            $display("[TB] FAIL multi_release: got pressed_low=%0d valids=%0d, expected 8 0", fpl, nv);
        end
    endtask

    task automatic test_reset_mid_hold();
        int fv, nv, fpl, fml, nph;
        logic [2:0] cv;
        logic mv;
        key = 8'hFD;
        observe(10, fv, nv, cv, mv, fpl, fml, nph);
        n_checks++;
        if (fv !== 8 || cv !== 3'd6) begin
            n_fail++;
            $display("[TB] FAIL midreset_first: got first=%0d code=%0d, expected 8 6", fv, cv);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({code, valid, pressed, multi} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL midreset_clear: got code=%0d valid=%b pressed=%b multi=%b, expected all 0",
                     code, valid, pressed, multi);
        end
        rst = 1'b0;
        observe(12, fv, nv, cv, mv, fpl, fml, nph);
        n_checks++;
        if (fv !== 8 || nv !== 1 || cv !== 3'd6) begin
            n_fail++;
            $display("[TB] FAIL midreset_second: got first=%0d count=%0d code=%0d, expected 8 1 6", fv, nv, cv);
        end
        key = 8'hFF;
        observe(12, fv, nv, cv, mv, fpl, fml, nph);
    endtask

    task automatic test_short_glitch();
        int fv, nv, fpl, fml, nph;
        int early;
        logic [2:0] cv;
        logic mv;
        early = 0;
        key = 8'hFE;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (valid === 1'b1 || pressed === 1'b1) early++;
        end
        key = 8'hFF;
        observe(15, fv, nv, cv, mv, fpl, fml, nph);
        n_checks++;
        if (early !== 0 || nv !== 0 || nph !== 0) begin
            n_fail++;
            $display("[TB] FAIL short_glitch: got early=%0d valids=%0d pressed_cycles=%0d, expected 0 0 0",
                     early, nv, nph);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        key      = 8'hFF;
        test_reset();
        test_single_keys();
        test_bounce();
        test_multi();
        test_reset_mid_hold();
        test_short_glitch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
